// File: rtl/cache_debug_checker.sv
// Passive checker for a core/cache pair: mirrors completed writes in a shadow table and flags reads whose data disagree.
// Optional first-mismatch capture registers are built when CHK_FIRST_ERR_CAPTURE_EN is defined.
module cache_debug_checker #(
  parameter int SHADOW_AW = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        core2cache_wr_en,
  input  logic [26:0] core2cache_wr_addr,
  input  logic [31:0] core2cache_wr_data,
  input  logic        core2cache_rd_en,
  input  logic [26:0] core2cache_rd_addr,
  input  logic        cache2core_wr_fin,
  input  logic        cache2core_rd_fin,
  input  logic [31:0] cache2core_rd_data,
  input  logic        clr,
  output logic        chk_busy,
  output logic [15:0] chk_rd_cnt,
  output logic [15:0] chk_err_cnt,
  output logic        chk_err,
  output logic        chk_proto_err,
  output logic [26:0] err_addr,
  output logic [31:0] err_exp,
  output logic [31:0] err_got
);

  localparam int DEPTH = 1 << SHADOW_AW;

  typedef enum logic [1:0] {IDLE, WR_PEND, RD_PEND} state_t;

  state_t              state, state_nxt;
  logic [26:0]         pend_addr;
  logic [31:0]         pend_data;
  logic [DEPTH-1:0]    sh_valid;
  logic [24:0]         sh_key  [DEPTH];
  logic [31:0]         sh_data [DEPTH];

  logic accept_wr, accept_rd, shadow_we, do_check, proto, slot_free;
  logic [SHADOW_AW-1:0] idx;
  logic hit, mismatch;

  assign idx      = pend_addr[SHADOW_AW+1:2];
  assign hit      = sh_valid[idx] && (sh_key[idx] == pend_addr[26:2]);
  assign mismatch = do_check && hit && (sh_data[idx] != cache2core_rd_data);
  assign chk_busy = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    shadow_we = 1'b0;
    do_check  = 1'b0;
    proto     = 1'b0;
    slot_free = 1'b0;
    case (state)
      IDLE: begin
        slot_free = 1'b1;
        if (cache2core_wr_fin || cache2core_rd_fin) proto = 1'b1;
      end
      WR_PEND: begin
        if (cache2core_wr_fin) begin
          shadow_we = 1'b1;
          slot_free = 1'b1;
          state_nxt = IDLE;
        end
        if (cache2core_rd_fin) proto = 1'b1;
      end
      RD_PEND: begin
        if (cache2core_rd_fin) begin
          do_check  = 1'b1;
          slot_free = 1'b1;
          state_nxt = IDLE;
        end
        if (cache2core_wr_fin) proto = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // A finishing request frees the slot in the same cycle, so a new request can ride along.
    if (core2cache_wr_en || core2cache_rd_en) begin
      if (!slot_free || (core2cache_wr_en && core2cache_rd_en)) proto = 1'b1;
      else if (core2cache_wr_en) begin
        accept_wr = 1'b1;
        state_nxt = WR_PEND;
      end else begin
        accept_rd = 1'b1;
        state_nxt = RD_PEND;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      pend_addr     <= '0;
      pend_data     <= '0;
      sh_valid      <= '0;
      chk_rd_cnt    <= '0;
      chk_err_cnt   <= '0;
      chk_err       <= 1'b0;
      chk_proto_err <= 1'b0;
    end else if (clr) begin
      state         <= IDLE;
      sh_valid      <= '0;
      chk_rd_cnt    <= '0;
      chk_err_cnt   <= '0;
      chk_err       <= 1'b0;
      chk_proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_wr) begin
        pend_addr <= core2cache_wr_addr;
        pend_data <= core2cache_wr_data;
      end else if (accept_rd) begin
        pend_addr <= core2cache_rd_addr;
      end
      if (shadow_we) sh_valid[idx] <= 1'b1;
      if (do_check && chk_rd_cnt != 16'hFFFF) chk_rd_cnt <= chk_rd_cnt + 16'd1;
      if (mismatch) begin
        chk_err <= 1'b1;
        if (chk_err_cnt != 16'hFFFF) chk_err_cnt <= chk_err_cnt + 16'd1;
      end
      if (proto) chk_proto_err <= 1'b1;
    end
  end

  // NOTE: key/data arrays carry no reset; the valid vector alone decides whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (shadow_we && !clr) begin
      sh_key[idx]  <= pend_addr[26:2];
      sh_data[idx] <= pend_data;
    end
  end

`ifdef CHK_FIRST_ERR_CAPTURE_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_addr <= '0;
      err_exp  <= '0;
      err_got  <= '0;
    end else if (clr) begin
      err_addr <= '0;
      err_exp  <= '0;
      err_got  <= '0;
    end else if (mismatch && !chk_err) begin
      err_addr <= pend_addr;
      err_exp  <= sh_data[idx];
      err_got  <= cache2core_rd_data;
    end
  end
`else
  assign err_addr = '0;
  assign err_exp  = '0;
  assign err_got  = '0;
  // Byte-offset bits only matter to the capture path.
  logic unused_addr_lo;
  assign unused_addr_lo = ^pend_addr[1:0];
`endif

endmodule

// File: tb/tb_cache_debug_checker.sv
// Directed self-checking bench for cache_debug_checker; inputs change #1 after the rising edge, outputs are sampled there.
module tb_cache_debug_checker;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0, wr_fin = 1'b0, rd_fin = 1'b0, clr = 1'b0;
  logic [26:0] wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0, rd_data = '0;
  logic        busy, err, proto_err;
  logic [15:0] rd_cnt, err_cnt;
  logic [26:0] err_addr;
  logic [31:0] err_exp, err_got;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  cache_debug_checker #(.SHADOW_AW(6)) dut (
    .clk(clk), .rstn(rstn),
    .core2cache_wr_en(wr_en), .core2cache_wr_addr(wr_addr), .core2cache_wr_data(wr_data),
    .core2cache_rd_en(rd_en), .core2cache_rd_addr(rd_addr),
    .cache2core_wr_fin(wr_fin), .cache2core_rd_fin(rd_fin), .cache2core_rd_data(rd_data),
    .clr(clr),
    .chk_busy(busy), .chk_rd_cnt(rd_cnt), .chk_err_cnt(err_cnt), .chk_err(err),
    .chk_proto_err(proto_err), .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic b, input logic [15:0] rc, input logic [15:0] ec,
                    input logic e, input logic p);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".rd_cnt"}, 32'(rd_cnt), 32'(rc));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(ec));
    check({tag, ".err"}, 32'(err), 32'(e));
    check({tag, ".proto"}, 32'(proto_err), 32'(p));
  endtask

  task automatic cap(input string tag, input logic [26:0] a, input logic [31:0] x, input logic [31:0] g);
`ifdef CHK_FIRST_ERR_CAPTURE_EN
    check({tag, ".err_addr"}, 32'(err_addr), 32'(a));
    check({tag, ".err_exp"}, err_exp, x);
    check({tag, ".err_got"}, err_got, g);
`else
    check({tag, ".err_addr"}, 32'(err_addr), 32'h0);
    check({tag, ".err_exp"}, err_exp, 32'h0);
    check({tag, ".err_got"}, err_got, 32'h0);
`endif
  endtask

  // One clock cycle with the given inputs held; everything returns to idle afterwards.
  task automatic cyc(input logic we, input logic [26:0] wa, input logic [31:0] wd,
                     input logic re, input logic [26:0] ra,
                     input logic wf, input logic rf, input logic [31:0] rdd, input logic c = 1'b0);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
    wr_fin = wf; rd_fin = rf; rd_data = rdd; clr = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; wr_fin = 1'b0; rd_fin = 1'b0; clr = 1'b0;
  endtask

  task automatic do_wr(input logic [26:0] a, input logic [31:0] d);
    cyc(1, a, d, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic do_rd(input logic [26:0] a, input logic [31:0] d);
    cyc(0, 0, 0, 1, a, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, d);
  endtask

  task automatic do_clr();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    st("reset", 0, 0, 0, 0, 0);
    cap("reset", 0, 0, 0);
    rstn = 1'b1;

    // Matching write/read pair.
    cyc(1, 27'h000_0000, 32'h5, 0, 0, 0, 0, 0);
    check("wr_accept.busy", 32'(busy), 32'h1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    check("wr_done.busy", 32'(busy), 32'h0);
    do_rd(27'h000_0000, 32'h5);
    st("match", 0, 1, 0, 0, 0);

    // Data mismatch and first-error capture.
    do_wr(27'h000_0040, 32'h7);
    do_rd(27'h000_0040, 32'h8);
    st("mism", 0, 2, 1, 1, 0);
    cap("mism", 27'h040, 32'h7, 32'h8);
    do_wr(27'h000_0000, 32'h9);
    do_rd(27'h000_0000, 32'hA);
    st("mism2", 0, 3, 2, 1, 0);
    cap("mism2", 27'h040, 32'h7, 32'h8);

    do_clr();
    st("clr1", 0, 0, 0, 0, 0);
    cap("clr1", 0, 0, 0);
    do_rd(27'h000_0040, 32'h8);
    st("clr1_unchecked", 0, 1, 0, 0, 0);

    // Unwritten entry, then key-differs at a shared index, then overwrite at that index.
    do_rd(27'h123_4560, 32'hDEAD_BEEF);
    st("unwritten", 0, 2, 0, 0, 0);
    do_wr(27'h000_0100, 32'h11);
    do_rd(27'h000_0000, 32'h99);
    st("key_diff", 0, 3, 0, 0, 0);
    do_rd(27'h000_0100, 32'h11);
    st("overwrite_ok", 0, 4, 0, 0, 0);
    do_rd(27'h000_0100, 32'h12);
    st("overwrite_bad", 0, 5, 1, 1, 0);
    cap("overwrite_bad", 27'h100, 32'h11, 32'h12);
    do_clr();

    // Simultaneous requests in IDLE, then a stray fin.
    cyc(1, 27'h10, 32'h1, 1, 27'h10, 0, 0, 0);
    st("both_en", 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0);
    st("fin_idle", 0, 0, 0, 0, 1);
    do_clr();
    check("clr_proto", 32'(proto_err), 32'h0);

    // Back-to-back: wr_fin with rd_en.
    cyc(1, 27'h080, 32'h33, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 27'h080, 1, 0, 0);
    st("b2b_pend", 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h33);
    st("b2b_done", 0, 1, 0, 0, 0);

    // Request while pending is ignored; cross-type fin while pending is an error that keeps the request.
    cyc(1, 27'h080, 32'h44, 0, 0, 0, 0, 0);
    cyc(1, 27'h0C0, 32'h55, 0, 0, 0, 0, 0);
    st("en_pend", 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    do_rd(27'h080, 32'h44);
    st("en_pend_rd", 0, 2, 0, 0, 1);
    do_rd(27'h0C0, 32'hFF);
    st("ignored_wr", 0, 3, 0, 0, 1);
    cyc(0, 0, 0, 1, 27'h080, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    check("wrfin_in_rd.busy", 32'(busy), 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h44);
    st("wrfin_in_rd", 0, 4, 0, 0, 1);
    do_clr();

    // Clear wins over a same-cycle request.
    cyc(1, 27'h040, 32'h1, 0, 0, 0, 0, 0, 1);
    st("clr_prio", 0, 0, 0, 0, 0);

    // Reset during a pending read discards it.
    cyc(0, 0, 0, 1, 27'h000, 0, 0, 0);
    rstn = 1'b0;
    #1;
    check("async_rst.busy", 32'(busy), 32'h0);
    #1 rstn = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0);
    st("fin_after_rst", 0, 0, 0, 0, 1);
    do_clr();

    // Saturation: 65535 back-to-back mismatching reads, then one more.
    do_wr(27'h040, 32'h7);
    cyc(0, 0, 0, 1, 27'h040, 0, 0, 0);
    for (int i = 0; i < 65534; i++) cyc(0, 0, 0, 1, 27'h040, 0, 1, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h8);
    st("sat_reach", 0, 16'hFFFF, 16'hFFFF, 1, 0);
    do_rd(27'h040, 32'h8);
    st("sat_hold", 0, 16'hFFFF, 16'hFFFF, 1, 0);
    cap("sat_hold", 27'h040, 32'h7, 32'h8);
    do_clr();
    st("sat_clr", 0, 0, 0, 0, 0);
    cap("sat_clr", 0, 0, 0);
    do_rd(27'h040, 32'h8);
    st("sat_clr_unchecked", 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
